// File: rtl/vc_dest_arbiter.sv
// -----------------------------------------------------------------------------
// vc_dest_arbiter
//
// Purpose:
//   Schedules words from two virtual-channel FIFOs (VC0, VC1) into two
//   destination FIFOs (D0, D1). At most one VC head word is granted per cycle.
//   The grant pops the VC FIFO combinationally. One cycle later the word is
//   pushed, unmodified, into the destination chosen by bit BW-2 of the word
//   (0 = D0, 1 = D1). VC sharing is weighted round-robin. A VC whose head word
//   targets an almost-full destination is not eligible for a grant.
//
// Ports:
//   clk             system clock
//   reset           synchronous reset, active-high
//   enable          arbitration enable
//   weight_vc0/1    maximum consecutive grants while the other VC is eligible
//                   (a weight of 0 is treated as 1)
//   vc0/1_empty     VC FIFO empty flags
//   vc0/1_data      VC FIFO head words (show-ahead)
//   d0/1_almost_full destination high-threshold flags
//   vc0/1_rd        VC pop strobes (combinational)
//   d0/1_wr         destination push strobes (registered)
//   d_data_out      word pushed to D0/D1 (registered)
//   arb_idle        registered; 1 when no grant was issued in the previous cycle
//
// Optional feature (macro ARB_STATS_EN):
//   Adds the 8-bit saturating counters gnt_cnt_vc0, gnt_cnt_vc1 (grants per VC)
//   and stall_cnt (cycles with a non-empty VC but no grant).
// -----------------------------------------------------------------------------
module vc_dest_arbiter #(
  parameter int BW       = 6,
  parameter int WEIGHT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [WEIGHT_W-1:0] weight_vc0,
  input  logic [WEIGHT_W-1:0] weight_vc1,
  input  logic                vc0_empty,
  input  logic                vc1_empty,
  input  logic [BW-1:0]       vc0_data,
  input  logic [BW-1:0]       vc1_data,
  input  logic                d0_almost_full,
  input  logic                d1_almost_full,
  output logic                vc0_rd,
  output logic                vc1_rd,
  output logic                d0_wr,
  output logic                d1_wr,
  output logic [BW-1:0]       d_data_out,
  output logic                arb_idle
`ifdef ARB_STATS_EN
  ,
  output logic [7:0]          gnt_cnt_vc0,
  output logic [7:0]          gnt_cnt_vc1,
  output logic [7:0]          stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_VC0 = 2'd1,
    SERVE_VC1 = 2'd2
  } state_t;

  localparam logic [WEIGHT_W-1:0] CNT_ONE = WEIGHT_W'(1);
  localparam logic [WEIGHT_W-1:0] CNT_MAX = {WEIGHT_W{1'b1}};

  state_t              state, state_nxt;
  logic [WEIGHT_W-1:0] burst_cnt, burst_cnt_nxt, burst_cnt_inc;
  logic                last_owner;  // 0 = VC0, 1 = VC1
  logic [WEIGHT_W-1:0] w0, w1;
  logic                elig0, elig1;
  logic                gnt0, gnt1;
  logic [BW-1:0]       gnt_data;

  // Effective weights: a zero weight still allows one grant per turn.
  assign w0 = (weight_vc0 == '0) ? CNT_ONE : weight_vc0;
  assign w1 = (weight_vc1 == '0) ? CNT_ONE : weight_vc1;

  // Only the head word is considered: a blocked head stalls its whole VC.
  assign elig0 = enable && !vc0_empty &&
                 !(vc0_data[BW-2] ? d1_almost_full : d0_almost_full);
  assign elig1 = enable && !vc1_empty &&
                 !(vc1_data[BW-2] ? d1_almost_full : d0_almost_full);

  assign burst_cnt_inc = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CNT_ONE;

  // Grant decision for the current cycle.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    state_nxt     = IDLE;
    burst_cnt_nxt = '0;
    unique case (state)
      SERVE_VC0: begin
        if (elig0 && (burst_cnt < w0 || !elig1)) begin
          gnt0          = 1'b1;
          state_nxt     = SERVE_VC0;
          burst_cnt_nxt = burst_cnt_inc;
        end else if (elig1) begin
          gnt1          = 1'b1;
          state_nxt     = SERVE_VC1;
          burst_cnt_nxt = CNT_ONE;
        end
      end
      SERVE_VC1: begin
        if (elig1 && (burst_cnt < w1 || !elig0)) begin
          gnt1          = 1'b1;
          state_nxt     = SERVE_VC1;
          burst_cnt_nxt = burst_cnt_inc;
        end else if (elig0) begin
          gnt0          = 1'b1;
          state_nxt     = SERVE_VC0;
          burst_cnt_nxt = CNT_ONE;
        end
      end
      default: begin
        // From IDLE the VC that did not own the last grant wins a tie.
        if (elig0 && (!elig1 || last_owner)) begin
          gnt0          = 1'b1;
          state_nxt     = SERVE_VC0;
          burst_cnt_nxt = CNT_ONE;
        end else if (elig1) begin
          gnt1          = 1'b1;
          state_nxt     = SERVE_VC1;
          burst_cnt_nxt = CNT_ONE;
        end
      end
    endcase
  end

  // Pops are suppressed while reset is held so no word is lost from a VC.
  assign vc0_rd   = gnt0 && !reset;
  assign vc1_rd   = gnt1 && !reset;
  assign gnt_data = gnt1 ? vc1_data : vc0_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;
      d0_wr      <= 1'b0;
      d1_wr      <= 1'b0;
      d_data_out <= '0;
      arb_idle   <= 1'b1;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      arb_idle  <= !(gnt0 || gnt1);
      d0_wr     <= (gnt0 || gnt1) && !gnt_data[BW-2];
      d1_wr     <= (gnt0 || gnt1) &&  gnt_data[BW-2];
      if (gnt0 || gnt1) begin
        d_data_out <= gnt_data;
        last_owner <= gnt1;
      end
    end
  end

`ifdef ARB_STATS_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt_vc0 <= '0;
      gnt_cnt_vc1 <= '0;
      stall_cnt   <= '0;
    end else begin
      if (gnt0) gnt_cnt_vc0 <= sat_inc(gnt_cnt_vc0);
      if (gnt1) gnt_cnt_vc1 <= sat_inc(gnt_cnt_vc1);
      if ((!vc0_empty || !vc1_empty) && !gnt0 && !gnt1)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vc_dest_arbiter
//
// Self-checking bench for vc_dest_arbiter. The VC FIFOs are modelled as
// queues; a reference model tracks the current owner and the run length of
// consecutive grants, and predicts each cycle's grant from the arbitration
// rules. Directed sequences from the test plan are followed by a randomized
// run. Define ARB_STATS_EN for both files to also check the statistics.
// -----------------------------------------------------------------------------
module tb_vc_dest_arbiter;

  localparam int BW       = 6;
  localparam int WEIGHT_W = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic [WEIGHT_W-1:0] weight_vc0, weight_vc1;
  logic                vc0_empty, vc1_empty;
  logic [BW-1:0]       vc0_data, vc1_data;
  logic                d0_almost_full, d1_almost_full;
  logic                vc0_rd, vc1_rd, d0_wr, d1_wr;
  logic [BW-1:0]       d_data_out;
  logic                arb_idle;
`ifdef ARB_STATS_EN
  logic [7:0]          gnt_cnt_vc0, gnt_cnt_vc1, stall_cnt;
`endif

  vc_dest_arbiter #(.BW(BW), .WEIGHT_W(WEIGHT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .weight_vc0     (weight_vc0),
    .weight_vc1     (weight_vc1),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .vc0_rd         (vc0_rd),
    .vc1_rd         (vc1_rd),
    .d0_wr          (d0_wr),
    .d1_wr          (d1_wr),
    .d_data_out     (d_data_out),
    .arb_idle       (arb_idle)
`ifdef ARB_STATS_EN
    ,
    .gnt_cnt_vc0    (gnt_cnt_vc0),
    .gnt_cnt_vc1    (gnt_cnt_vc1),
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // VC FIFO contents seen by the DUT.
  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];

  // Reference model: owner of the current run (-1 = none), length of the run,
  // last VC granted, plus expectations for the registered outputs.
  int            m_owner, m_run, m_last;
  logic          e_wr0, e_wr1, e_idle;
  logic [BW-1:0] e_data;
  int            m_g0, m_g1, m_st;
  int            act_g;  // grant observed on the DUT's rd strobes this step
  int            glog[$];

  function automatic int eff_w(input logic [WEIGHT_W-1:0] w);
    return (w == 0) ? 1 : int'(w);
  endfunction

  function automatic int model_grant(input bit e0, input bit e1);
    bit ek, eo;
    int wk;
    if (m_owner >= 0) begin
      ek = (m_owner == 0) ? e0 : e1;
      eo = (m_owner == 0) ? e1 : e0;
      wk = (m_owner == 0) ? eff_w(weight_vc0) : eff_w(weight_vc1);
      if (ek && (m_run < wk || !eo)) return m_owner;
      if (eo) return 1 - m_owner;
      return -1;
    end
    if (e0 && e1) return 1 - m_last;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_last = 1;
    e_wr0 = 0; e_wr1 = 0; e_idle = 1; e_data = '0;
    m_g0 = 0; m_g1 = 0; m_st = 0;
  endtask

  task automatic drive_heads();
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    vc0_data  = vc0_empty ? BW'($urandom) : q0[0];
    vc1_data  = vc1_empty ? BW'($urandom) : q1[0];
  endtask

  // One clock of arbitration: check the combinational pops, then the
  // registered push one edge later.
  task automatic step();
    bit            e0, e1, nonempty;
    int            g;
    logic [BW-1:0] word;
    drive_heads();
    #1;
    e0 = enable && !vc0_empty && !(vc0_data[BW-2] ? d1_almost_full : d0_almost_full);
    e1 = enable && !vc1_empty && !(vc1_data[BW-2] ? d1_almost_full : d0_almost_full);
    g  = model_grant(e0, e1);
    check("vc0_rd", vc0_rd, g == 0);
    check("vc1_rd", vc1_rd, g == 1);
    act_g = vc1_rd ? 1 : (vc0_rd ? 0 : -1);
    glog.push_back(act_g);
    nonempty = !vc0_empty || !vc1_empty;
    if (g >= 0) begin
      word    = (g == 0) ? q0.pop_front() : q1.pop_front();
      m_run   = (g == m_owner) ? sat(m_run + 1, 15) : 1;
      m_owner = g;
      m_last  = g;
      e_data  = word;
      e_wr0   = !word[BW-2];
      e_wr1   = word[BW-2];
      e_idle  = 0;
      if (g == 0) m_g0 = sat(m_g0 + 1, 255);
      else        m_g1 = sat(m_g1 + 1, 255);
    end else begin
      m_owner = -1; m_run = 0;
      e_wr0 = 0; e_wr1 = 0; e_idle = 1;
      if (nonempty) m_st = sat(m_st + 1, 255);
    end
    @(posedge clk);
    #1;
    check("d0_wr", d0_wr, e_wr0);
    check("d1_wr", d1_wr, e_wr1);
    check("d_data_out", d_data_out, e_data);
    check("arb_idle", arb_idle, e_idle);
`ifdef ARB_STATS_EN
    check("gnt_cnt_vc0", gnt_cnt_vc0, m_g0);
    check("gnt_cnt_vc1", gnt_cnt_vc1, m_g1);
    check("stall_cnt", stall_cnt, m_st);
`endif
  endtask

  // Synchronous reset; pops must stay low while reset is held.
  task automatic do_reset();
    reset = 1'b1;
    drive_heads();
    #1;
    check("rst_vc0_rd", vc0_rd, 1'b0);
    check("rst_vc1_rd", vc1_rd, 1'b0);
    @(posedge clk);
    #1;
    model_reset();
    check("rst_d0_wr", d0_wr, 1'b0);
    check("rst_d1_wr", d1_wr, 1'b0);
    check("rst_data", d_data_out, '0);
    check("rst_idle", arb_idle, 1'b1);
`ifdef ARB_STATS_EN
    check("rst_stall", stall_cnt, 8'd0);
`endif
    reset = 1'b0;
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); glog.delete();
    enable = 1'b1; d0_almost_full = 1'b0; d1_almost_full = 1'b0;
  endtask

  initial begin
    int exp_seq[$];
    reset = 1'b1; enable = 1'b0;
    weight_vc0 = '0; weight_vc1 = '0;
    d0_almost_full = 1'b0; d1_almost_full = 1'b0;
    model_reset();
    drive_heads();
    repeat (2) @(posedge clk);
    #1;

    // Single word VC0 -> D0.
    clear_all();
    do_reset();
    q0.push_back(6'b00_0001);
    step();
    check("t1_grant", act_g, 0);
    check("t1_d0_wr", d0_wr, 1'b1);
    check("t1_data", d_data_out, 6'b00_0001);
    check("t1_idle", arb_idle, 1'b0);

    // Weighted round-robin 2:1, six words each, alternating destinations.
    clear_all();
    weight_vc0 = 4'd2; weight_vc1 = 4'd1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      q0.push_back({1'b0, i[0], 4'(i)});
      q1.push_back({1'b1, ~i[0], 4'(i)});
    end
    repeat (12) step();
    exp_seq = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 12; i++) check("wrr_order", glog[i], exp_seq[i]);

    // Head-of-line blocking on an almost-full destination.
    clear_all();
    do_reset();
    q0.push_back(6'b01_0100);
    q1.push_back(6'b10_0001);
    d1_almost_full = 1'b1;
    step();
    check("af_grant_vc1", act_g, 1);
    check("af_d0_wr", d0_wr, 1'b1);
    d1_almost_full = 1'b0;
    step();
    check("af_release_vc0", act_g, 0);
    check("af_d1_wr", d1_wr, 1'b1);

    // Zero weights behave as weight 1: strict alternation.
    clear_all();
    weight_vc0 = '0; weight_vc1 = '0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(6'(i));
      q1.push_back(6'(16 + i));
    end
    repeat (8) step();
    for (int i = 0; i < 8; i++) check("w0_alternate", glog[i], i % 2);

    // Enable low with both VCs holding data.
    clear_all();
    do_reset();
    q0.push_back(6'h05); q1.push_back(6'h25);
    enable = 1'b0;
    repeat (5) step();
    check("dis_idle", arb_idle, 1'b1);
`ifdef ARB_STATS_EN
    check("dis_stall5", stall_cnt, 8'd5);
`endif
    enable = 1'b1;

    // Reset right after a grant drops the pending push; VC0 wins afterwards.
    clear_all();
    weight_vc0 = 4'd3; weight_vc1 = 4'd3;
    do_reset();
    q1.push_back(6'h11); q1.push_back(6'h12);
    step();
    check("mid_grant_vc1", act_g, 1);
    q0.push_back(6'h03);
    do_reset();
    step();
    check("post_rst_vc0", act_g, 0);

    // Randomized traffic with changing weights and backpressure.
    clear_all();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) begin
        weight_vc0 = WEIGHT_W'($urandom_range(0, 5));
        weight_vc1 = WEIGHT_W'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 99) < 45) q0.push_back(BW'($urandom));
      if ($urandom_range(0, 99) < 45) q1.push_back(BW'($urandom));
      d0_almost_full = ($urandom_range(0, 99) < 20);
      d1_almost_full = ($urandom_range(0, 99) < 20);
      enable         = ($urandom_range(0, 99) < 92);
      if (c == 200) do_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
